monobit_stream_gen: RTL

Bit-serial stimulus source that produces framed test blocks for the monobit (frequency) tester. It emits blocks of pseudo-random or fixed-pattern bits over a valid/ready handshake. It also keeps its own count of the ones it emitted, so the tester's result can be self-checked on-chip. It sits upstream of the tester inside tt_um_example and is controlled from ui_in/uio_in.

---
 rtl/monobit_stream_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/monobit_stream_gen.sv
// Framed bit-serial stimulus source for the monobit tester: LFSR-biased or fixed-pattern
// blocks over a valid/ready handshake, with an on-chip count of emitted ones.
module monobit_stream_gen #(
    parameter int LEN_W  = 8,
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        bias,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LEN_W-1:0]  block_len,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    ones_count
);

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(16'hACE1);
    localparam logic [LFSR_W-1:0] LFSR_POLY    = LFSR_W'(16'hB400);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_phase;
    logic [1:0]        r_mode;
    logic [7:0]        r_bias;
    logic [LEN_W:0]    r_remaining;
    logic [LEN_W:0]    r_ones;
    logic              r_bit_out;
    logic              r_bit_valid;
    logic              r_bit_last;
    logic              r_busy;
    logic              r_done;

    logic [LFSR_W-1:0] w_seed_val;
    logic [LFSR_W-1:0] w_start_lfsr;
    logic [LEN_W:0]    w_len;
    logic              w_accept;
    logic [LFSR_W-1:0] w_lfsr_step;
    logic [LFSR_W-1:0] w_run_lfsr;
    logic              w_run_phase;

    // Bit generator evaluated on the state the next beat will present.
    function automatic logic gen_bit(input logic [1:0] md, input logic [7:0] bs,
                                     input logic [7:0] lf_low, input logic ph);
        case (md)
            2'd0:    return (lf_low < bs);
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return ph;
        endcase
    endfunction

    always_comb begin
        w_seed_val   = (seed == '0) ? SEED_DEFAULT : seed;
        w_start_lfsr = seed_load ? w_seed_val : r_lfsr;
        w_len        = (block_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, block_len};
        w_accept     = r_bit_valid & bit_ready;
        w_lfsr_step  = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_POLY : '0);
        w_run_lfsr   = (r_mode == 2'd0) ? w_lfsr_step : r_lfsr;
        w_run_phase  = (r_mode == 2'd3) ? ~r_phase : r_phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED_DEFAULT;
            r_phase     <= 1'b1;
            r_mode      <= 2'd0;
            r_bias      <= 8'd0;
            r_remaining <= '0;
            r_ones      <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= w_seed_val;
                    end
                    // A seed loaded alongside start is already visible to the first bit.
                    if (start) begin
                        r_state     <= S_RUN;
                        r_mode      <= mode;
                        r_bias      <= bias;
                        r_remaining <= w_len;
                        r_phase     <= 1'b1;
                        r_ones      <= '0;
                        r_bit_valid <= 1'b1;
                        r_bit_out   <= gen_bit(mode, bias, w_start_lfsr[7:0], 1'b1);
                        r_bit_last  <= (w_len == (LEN_W+1)'(1));
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_ones      <= r_ones + (LEN_W+1)'(r_bit_out);
                        r_remaining <= r_remaining - (LEN_W+1)'(1);
                        r_lfsr      <= w_run_lfsr;
                        r_phase     <= w_run_phase;
                        if (r_bit_last) begin
                            r_state     <= S_DONE;
                            r_bit_valid <= 1'b0;
                            r_bit_out   <= 1'b0;
                            r_bit_last  <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_bit_out  <= gen_bit(r_mode, r_bias, w_run_lfsr[7:0], w_run_phase);
                            r_bit_last <= (r_remaining == (LEN_W+1)'(2));
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign bit_last   = r_bit_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ones_count = r_ones;

endmodule
